// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with TX FIFO, STATUS (W1C overflow) and DIV registers.
// Optional even-parity bit between data and stop: define MMIO_UART_PARITY_EN.
module mmio_uart_tx #(
    parameter int                    addr_width = 32,
    parameter int                    data_width = 32,
    parameter logic [addr_width-1:0] base_addr  = 32'hFFFF_0000,
    parameter int                    fifo_depth = 4,
    parameter logic [15:0]           reset_div  = 16'd4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wen,
    input  logic [3:0]            byte_en,
    input  logic [addr_width-1:0] addr,
    inout  wire  [data_width-1:0] data,
    output logic                  tx
);

    localparam int         PW      = $clog2(fifo_depth);
    localparam logic [4:0] DEPTH_C = 5'(fifo_depth);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
`ifdef MMIO_UART_PARITY_EN
        , S_PARITY
`endif
    } state_t;

    state_t          r_state;
    logic [15:0]     r_cnt;
    logic [2:0]      r_idx;
    logic            r_tx;
    logic [7:0]      r_shift;
    logic [15:0]     r_div;
    logic            r_ovf;
    logic [4:0]      r_count;
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic [7:0]      r_mem [0:fifo_depth-1];
`ifdef MMIO_UART_PARITY_EN
    logic            r_par;
`endif

    state_t          w_state_nxt;
    logic [15:0]     w_cnt_nxt;
    logic [2:0]      w_idx_nxt;
    logic            w_tx_nxt;
    logic            w_pop;
    logic            w_shift_en;
    logic            w_sel;
    logic            w_wr;
    logic [1:0]      w_off;
    logic            w_push;
    logic            w_push_ok;
    logic            w_ovf_clr;
    logic            w_full;
    logic            w_empty;
    logic            w_busy;
    logic [15:0]     w_reload;
    logic [data_width-1:0] w_rdata;
    logic            w_unused;

    assign w_sel     = (addr[addr_width-1:4] == base_addr[addr_width-1:4]);
    assign w_off     = addr[3:2];
    assign w_wr      = w_sel && wen;
    assign w_full    = (r_count == DEPTH_C);
    assign w_empty   = (r_count == 5'd0);
    assign w_busy    = (r_state != S_IDLE);
    assign w_push    = w_wr && (w_off == 2'd0) && byte_en[0];
    assign w_push_ok = w_push && (!w_full || w_pop);
    assign w_ovf_clr = w_wr && (w_off == 2'd1) && byte_en[0] && data[3];
    // A programmed divisor of 0 behaves as 1, so the reload value is never negative.
    assign w_reload  = (r_div == 16'd0) ? 16'd0 : (r_div - 16'd1);
    assign w_unused  = &{1'b0, addr[1:0], data[data_width-1:16]};

    always_comb begin
        w_rdata = '0;
        case (w_off)
            2'd1:    w_rdata[7:0]  = {r_count[3:0], r_ovf, w_empty, w_full, w_busy};
            2'd2:    w_rdata[15:0] = r_div;
            default: w_rdata = '0;
        endcase
    end

    assign data = (w_sel && !wen) ? w_rdata : 'z;
    assign tx   = r_tx;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_tx_nxt    = r_tx;
        w_pop       = 1'b0;
        w_shift_en  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_tx_nxt = 1'b1;
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_START;
                    w_cnt_nxt   = w_reload;
                    w_tx_nxt    = 1'b0;
                end
            end
            S_START: begin
                if (r_cnt == 16'd0) begin
                    w_state_nxt = S_DATA;
                    w_cnt_nxt   = w_reload;
                    w_idx_nxt   = 3'd0;
                    w_tx_nxt    = r_shift[0];
                end else begin
                    w_cnt_nxt = r_cnt - 16'd1;
                end
            end
            S_DATA: begin
                if (r_cnt == 16'd0) begin
                    w_cnt_nxt = w_reload;
                    if (r_idx == 3'd7) begin
`ifdef MMIO_UART_PARITY_EN
                        w_state_nxt = S_PARITY;
                        w_tx_nxt    = r_par;
`else
                        w_state_nxt = S_STOP;
                        w_tx_nxt    = 1'b1;
`endif
                    end else begin
                        w_idx_nxt  = r_idx + 3'd1;
                        w_tx_nxt   = r_shift[1];
                        w_shift_en = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 16'd1;
                end
            end
`ifdef MMIO_UART_PARITY_EN
            S_PARITY: begin
                if (r_cnt == 16'd0) begin
                    w_state_nxt = S_STOP;
                    w_cnt_nxt   = w_reload;
                    w_tx_nxt    = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 16'd1;
                end
            end
`endif
            S_STOP: begin
                // Back-to-back frames: a waiting byte starts its start bit with no idle gap.
                if (r_cnt == 16'd0) begin
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = S_START;
                        w_cnt_nxt   = w_reload;
                        w_tx_nxt    = 1'b0;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_tx_nxt    = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 16'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 16'd0;
            r_idx   <= 3'd0;
            r_tx    <= 1'b1;
            r_div   <= reset_div;
            r_ovf   <= 1'b0;
            r_count <= 5'd0;
            r_wptr  <= '0;
            r_rptr  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_tx    <= w_tx_nxt;
            if (w_wr && (w_off == 2'd2)) begin
                if (byte_en[0]) r_div[7:0]  <= data[7:0];
                if (byte_en[1]) r_div[15:8] <= data[15:8];
            end
            // Set has priority over a same-cycle W1C clear.
            if (w_push && !w_push_ok) r_ovf <= 1'b1;
            else if (w_ovf_clr)       r_ovf <= 1'b0;
            if (w_push_ok) r_wptr <= r_wptr + PW'(1);
            if (w_pop)     r_rptr <= r_rptr + PW'(1);
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + 5'd1;
                2'b01:   r_count <= r_count - 5'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wptr] <= data[7:0];
        if (w_pop) begin
            r_shift <= r_mem[r_rptr];
`ifdef MMIO_UART_PARITY_EN
            r_par   <= ^r_mem[r_rptr];
`endif
        end else if (w_shift_en) begin
            r_shift <= {1'b0, r_shift[7:1]};
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: register table plus hand-written frame, FIFO, DIV and reset sequences.
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE = 32'hFFFF_0000;

    logic        clk;
    logic        rst_n;
    logic        wen;
    logic [3:0]  byte_en;
    logic [31:0] addr;
    wire  [31:0] data;
    logic        tx;
    logic        tb_oe;
    logic [31:0] tb_wd;

    int total = 0;
    int bad   = 0;

    assign data = tb_oe ? tb_wd : 'z;

    mmio_uart_tx #(
        .addr_width(32),
        .data_width(32),
        .base_addr (32'hFFFF_0000),
        .fifo_depth(4),
        .reset_div (16'd4)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .wen    (wen),
        .byte_en(byte_en),
        .addr   (addr),
        .data   (data),
        .tx     (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got no-finish want finish");
        $fatal(1);
    end

    typedef struct {
        logic        is_wr;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
        logic [31:0] exp;
        string       nm;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        addr    = a;
        wen     = 1'b1;
        byte_en = be;
        tb_wd   = d;
        tb_oe   = 1'b1;
        @(posedge clk);
        #1;
        wen     = 1'b0;
        tb_oe   = 1'b0;
        byte_en = 4'h0;
        addr    = 32'h0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        addr    = a;
        wen     = 1'b0;
        byte_en = 4'h0;
        #1;
        d = data;
    endtask

    // Caller is 1ns after the edge that drove tx low; checks every clock of the frame.
    task automatic frame_check(input logic [7:0] b, input int d, input string nm);
        logic        bits [0:10];
        int          nb;
        logic [31:0] s;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = b[i];
`ifdef MMIO_UART_PARITY_EN
        bits[9]  = ^b;
        bits[10] = 1'b1;
        nb = 11;
`else
        bits[9]  = 1'b1;
        bits[10] = 1'b1;
        nb = 10;
`endif
        for (int bi = 0; bi < nb; bi++) begin
            for (int c = 0; c < d; c++) begin
                if (!(bi == 0 && c == 0)) begin
                    @(posedge clk);
                    #1;
                end
                chk($sformatf("%s_bit%0d_clk%0d", nm, bi, c), {31'b0, tx}, {31'b0, bits[bi]});
                if (bi == 5 && c == 0) begin
                    rd(BASE + 32'h4, s);
                    chk($sformatf("%s_busy", nm), {31'b0, s[0]}, 32'h1);
                end
            end
        end
    endtask

    task automatic wait_idle(input int max_cyc);
        logic [31:0] s;
        int          n;
        n = 0;
        rd(BASE + 32'h4, s);
        while ((s[0] || !s[2]) && n < max_cyc) begin
            @(posedge clk);
            #1;
            rd(BASE + 32'h4, s);
            n++;
        end
        chk("drain_idle", {30'b0, s[2], s[0]}, 32'h2);
    endtask

    initial begin
        logic [31:0] r;
        int          errs;
        rst_n   = 1'b0;
        wen     = 1'b0;
        byte_en = 4'h0;
        addr    = 32'h0;
        tb_oe   = 1'b0;
        tb_wd   = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_tx", {31'b0, tx}, 32'h1);

        tbl.push_back('{1'b0, BASE + 32'h4, 32'h0,         4'h0, 32'h0000_0004, "rst_status"});
        tbl.push_back('{1'b0, BASE + 32'h8, 32'h0,         4'h0, 32'h0000_0004, "rst_div"});
        tbl.push_back('{1'b0, BASE + 32'h0, 32'h0,         4'h0, 32'h0000_0000, "txdata_rd0"});
        tbl.push_back('{1'b0, BASE + 32'hC, 32'h0,         4'h0, 32'h0000_0000, "rsvd_rd0"});
        tbl.push_back('{1'b1, BASE + 32'h8, 32'h0000_AB99, 4'h2, 32'h0,         "wr_div_hi"});
        tbl.push_back('{1'b0, BASE + 32'h8, 32'h0,         4'h0, 32'h0000_AB04, "div_hi_only"});
        tbl.push_back('{1'b1, BASE + 32'h8, 32'h0000_0012, 4'h1, 32'h0,         "wr_div_lo"});
        tbl.push_back('{1'b0, BASE + 32'h8, 32'h0,         4'h0, 32'h0000_AB12, "div_lo_only"});
        tbl.push_back('{1'b1, BASE + 32'h8, 32'hFFFF_FFFF, 4'hC, 32'h0,         "wr_div_upper"});
        tbl.push_back('{1'b0, BASE + 32'h8, 32'h0,         4'h0, 32'h0000_AB12, "div_upper_lanes"});
        tbl.push_back('{1'b1, BASE + 32'hC, 32'hFFFF_FFFF, 4'hF, 32'h0,         "wr_rsvd"});
        tbl.push_back('{1'b0, BASE + 32'hC, 32'h0,         4'h0, 32'h0000_0000, "rsvd_wr_ignored"});
        tbl.push_back('{1'b1, BASE + 32'h8, 32'h0000_0004, 4'h3, 32'h0,         "wr_div_4"});
        tbl.push_back('{1'b0, BASE + 32'h8, 32'h0,         4'h0, 32'h0000_0004, "div_restore"});
        tbl.push_back('{1'b1, BASE + 32'h0, 32'h0000_0055, 4'h2, 32'h0,         "wr_tx_no_be0"});
        tbl.push_back('{1'b0, BASE + 32'h4, 32'h0,         4'h0, 32'h0000_0004, "push_needs_be0"});
        tbl.push_back('{1'b1, BASE + 32'h4, 32'h0000_0008, 4'h1, 32'h0,         "w1c_idle"});
        tbl.push_back('{1'b0, BASE + 32'h4, 32'h0,         4'h0, 32'h0000_0004, "w1c_idle_status"});

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].is_wr) begin
                wr(tbl[i].a, tbl[i].d, tbl[i].be);
            end else begin
                rd(tbl[i].a, r);
                chk(tbl[i].nm, r, tbl[i].exp);
            end
        end

        // Single 0x55 frame at div 4: tx falls on the second edge.
        wr(BASE, 32'h55, 4'h1);
        chk("lat_still_high", {31'b0, tx}, 32'h1);
        @(posedge clk);
        #1;
        frame_check(8'h55, 4, "f55");
        @(posedge clk);
        #1;
        chk("f55_idle_tx", {31'b0, tx}, 32'h1);
        rd(BASE + 32'h4, r);
        chk("f55_done_status", r, 32'h4);

        // Two queued bytes: the second frame follows the stop bit with no idle clock.
        wr(BASE, 32'h0F, 4'h1);
        wr(BASE, 32'h07, 4'h1);
        frame_check(8'h0F, 4, "f0f");
        @(posedge clk);
        #1;
        frame_check(8'h07, 4, "f07");
        @(posedge clk);
        #1;
        rd(BASE + 32'h4, r);
        chk("b2b_done_status", r, 32'h4);

        // div 0 behaves as 1.
        wr(BASE + 32'h8, 32'h0, 4'h3);
        wr(BASE, 32'h3C, 4'h1);
        @(posedge clk);
        #1;
        frame_check(8'h3C, 1, "div0");
        @(posedge clk);
        #1;
        rd(BASE + 32'h4, r);
        chk("div0_done_status", r, 32'h4);
        wr(BASE + 32'h8, 32'h4, 4'h3);

        // Burst of six writes into a depth-4 FIFO.
        for (int i = 0; i < 6; i++) wr(BASE, 32'hA0 + i, 4'h1);
        rd(BASE + 32'h4, r);
        chk("burst_status", r, 32'h4B);
        wr(BASE + 32'h4, 32'h8, 4'h0);
        rd(BASE + 32'h4, r);
        chk("w1c_needs_be0", r, 32'h4B);
        wr(BASE + 32'h4, 32'h8, 4'h1);
        rd(BASE + 32'h4, r);
        chk("w1c_cleared", r, 32'h43);
        wait_idle(2000);
        rd(BASE + 32'h4, r);
        chk("burst_drained", r, 32'h4);

        // DIV 4 -> 16 written during the start bit, then reset during a data bit.
        wr(BASE, 32'h55, 4'h1);
        @(posedge clk);
        #1;
        chk("div_chg_start0", {31'b0, tx}, 32'h0);
        wr(BASE + 32'h8, 32'h10, 4'h3);
        chk("div_chg_start1", {31'b0, tx}, 32'h0);
        for (int k = 2; k < 36; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("div_chg_k%0d", k), {31'b0, tx},
                (k < 4) ? 32'h0 : ((k < 20) ? 32'h1 : 32'h0));
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_tx", {31'b0, tx}, 32'h1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        rd(BASE + 32'h4, r);
        chk("rst_mid_status", r, 32'h4);
        rd(BASE + 32'h8, r);
        chk("rst_mid_div", r, 32'h4);
        errs = 0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk);
            #1;
            if (tx !== 1'b1) errs++;
        end
        chk("no_residual_bits", errs, 32'h0);

        // Other responders on the bus: the block must stay off data.
        addr  = BASE + 32'h14;
        wen   = 1'b0;
        tb_wd = 32'h1234_5670;
        tb_oe = 1'b1;
        #1;
        chk("out_of_window_rd", data, 32'h1234_5670);
        addr  = 32'h0000_0104;
        tb_wd = 32'hCAFE_0000;
        #1;
        chk("ram_rd", data, 32'hCAFE_0000);
        tb_oe = 1'b0;
        wr(BASE + 32'h10, 32'h33, 4'h1);
        @(posedge clk);
        #1;
        rd(BASE + 32'h4, r);
        chk("out_of_window_wr", r, 32'h4);
        chk("out_of_window_tx", {31'b0, tx}, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
